// File: rtl/alu_arbiter_ctrl.sv
// Two-port round-robin arbiter and sequencer for a shared two-operand ALU.
// Drives registered ALU operand/function/enable pins and returns tagged results.
module alu_arbiter_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FUNC_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0_VALID,
  output logic                    REQ0_READY,
  input  logic [DATA_WIDTH-1:0]   REQ0_A,
  input  logic [DATA_WIDTH-1:0]   REQ0_B,
  input  logic [FUNC_WIDTH-1:0]   REQ0_FUNC,
  input  logic                    REQ1_VALID,
  output logic                    REQ1_READY,
  input  logic [DATA_WIDTH-1:0]   REQ1_A,
  input  logic [DATA_WIDTH-1:0]   REQ1_B,
  input  logic [FUNC_WIDTH-1:0]   REQ1_FUNC,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic                    RSP_ID,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_ERR,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [FUNC_WIDTH-1:0]   ALU_FUNC,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_RESULT,
  input  logic                    ALU_RESULT_VALID
);

  localparam int unsigned ResW = 2 * DATA_WIDTH;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FUNC_WIDTH-1:0] FuncMax = FUNC_WIDTH'(13);
  localparam logic [FUNC_WIDTH-1:0] FuncDiv = FUNC_WIDTH'(3);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StExec, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic ready0_q, ready0_d;
  logic ready1_q, ready1_d;
  logic last_q, last_d;

  logic acc0, acc1, accept;
  logic win0, win1;
  logic illegal;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [FUNC_WIDTH-1:0] sel_func;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnt_last;

  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [FUNC_WIDTH-1:0] alu_func_q, alu_func_d;
  logic                  alu_en_q, alu_en_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [ResW-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  // Acceptance, payload selection and legality of the winning request.
  always_comb begin
    acc0     = (state_q == StIdle) & REQ0_VALID & ready0_q;
    acc1     = (state_q == StIdle) & REQ1_VALID & ready1_q;
    accept   = acc0 | acc1;
    sel_a    = acc1 ? REQ1_A : REQ0_A;
    sel_b    = acc1 ? REQ1_B : REQ0_B;
    sel_func = acc1 ? REQ1_FUNC : REQ0_FUNC;
    illegal  = (sel_func > FuncMax) | ((sel_func == FuncDiv) & (sel_b == '0));
    // last_q==1 means requester 1 was granted last, so requester 0 wins a tie
    win0     = REQ0_VALID & (~REQ1_VALID | last_q);
    win1     = REQ1_VALID & (~REQ0_VALID | ~last_q);
    cnt_last = (cnt_q == CntLast);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_d  = acc1;
          state_d = illegal ? StResp : StLoad;
        end
      end
      StLoad: state_d = StExec;
      StExec: state_d = StWait;
      StWait: begin
        if (ALU_RESULT_VALID || cnt_last) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (RSP_READY) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // READY is precomputed for the cycle we will spend in IDLE, so a request
    // can be accepted on the first IDLE cycle after a response completes.
    ready0_d = (state_d == StIdle) & win0;
    ready1_d = (state_d == StIdle) & win1;
  end

  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    alu_en_d    = (state_q == StLoad);
    cnt_d       = (state_q == StWait) ? cnt_q + CntW'(1) : '0;
    rsp_valid_d = (state_d == StResp);
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    if (accept) begin
      rsp_id_d = acc1;
      if (illegal) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end else begin
        // Operands are registered at acceptance so they are stable for all of LOAD.
        alu_a_d    = sel_a;
        alu_b_d    = sel_b;
        alu_func_d = sel_func;
      end
    end

    if (state_q == StWait) begin
      if (ALU_RESULT_VALID) begin
        rsp_data_d = ALU_RESULT;
        rsp_err_d  = 1'b0;
      end else if (cnt_last) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      alu_en_q    <= alu_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign REQ0_READY = ready0_q;
  assign REQ1_READY = ready1_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_ID     = rsp_id_q;
  assign RSP_DATA   = rsp_data_q;
  assign RSP_ERR    = rsp_err_q;
  assign ALU_A      = alu_a_q;
  assign ALU_B      = alu_b_q;
  assign ALU_FUNC   = alu_func_q;
  assign ALU_EN     = alu_en_q;

endmodule

// File: doc/alu_arbiter_ctrl.md
# alu_arbiter_ctrl

Two-port round-robin arbiter and sequencer for the shared two-operand ALU. It accepts operation requests from two independent requesters over valid/ready handshakes. It drives the ALU operand, function and enable pins with the ALU's required timing and returns each result, tagged with the requester ID, over a valid/ready response channel. It also rejects illegal operations and times out a non-responding ALU.

## Interface
- DATA_WIDTH, 8, operand width; result width is 2*DATA_WIDTH
- FUNC_WIDTH, 4, ALU function code width
- TIMEOUT_CYCLES, 8, maximum cycles spent in WAIT before an error response
- CLK  in  1  single clock; all logic rising-edge
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- REQ0_VALID, REQ1_VALID  in  1  request present
- REQ0_READY, REQ1_READY  out  1  request accepted this cycle when VALID&READY
- REQ0_A/REQ0_B, REQ1_A/REQ1_B  in  DATA_WIDTH  operands
- REQ0_FUNC, REQ1_FUNC  in  FUNC_WIDTH  function code (0..13 legal)
- RSP_VALID  out  1  response present
- RSP_READY  in  1  consumer accepts response
- RSP_ID  out  1  requester index of response
- RSP_DATA  out  2*DATA_WIDTH  result
- RSP_ERR  out  1  illegal op, divide-by-zero or timeout
- ALU_A, ALU_B  out  DATA_WIDTH  to ALU operand inputs (registered)
- ALU_FUNC  out  FUNC_WIDTH  to ALU function select (registered)
- ALU_EN  out  1  to ALU enable (registered, single-cycle pulse)
- ALU_RESULT  in  2*DATA_WIDTH  from ALU output (zero unless valid)
- ALU_RESULT_VALID  in  1  from ALU output-valid
- The ALU's own reset is active-low; the integrating level drives it with ~RST.

## Operation
- FSM states: IDLE, LOAD, EXEC, WAIT, RESP. Reset state is IDLE.
- IDLE: the arbiter picks a winner and asserts READY only on the winner (at most one READY high).
  - Round-robin: if both VALID, grant the requester not granted last. If one VALID, grant it.
  - The last-grant pointer updates only on acceptance. Reset value favours requester 0.
- On acceptance, capture A, B, FUNC and ID into holding registers.
  - FUNC>13, or FUNC==3 with B==0: go to RESP with DATA=0 and ERR=1. No ALU activity.
  - Otherwise go to LOAD.
- LOAD: ALU_A/ALU_B/ALU_FUNC drive the held values (the ALU registers operands at the end of this cycle) -> EXEC.
- EXEC: ALU_EN=1 for exactly this cycle -> WAIT.
- WAIT: on ALU_RESULT_VALID=1, capture ALU_RESULT into RSP_DATA with ERR=0 -> RESP.
  - If a cycle counter reaches TIMEOUT_CYCLES first: DATA=0, ERR=1 -> RESP.
- RESP: RSP_VALID=1. RSP_ID, RSP_DATA and RSP_ERR are held stable until RSP_READY=1, then -> IDLE.
- ALU_A, ALU_B and ALU_FUNC hold their values from LOAD through RESP; they change only in LOAD.
- One operation is in flight at a time; REQx_READY=0 outside IDLE.

## Timing
- Reset values:
  - State IDLE.
  - REQ0_READY=0, REQ1_READY=0 (registered; READY is first asserted the cycle after a VALID is seen in IDLE).
  - RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_ERR=0.
  - ALU_A=0, ALU_B=0, ALU_FUNC=0, ALU_EN=0.
  - Grant pointer=1, timeout counter=0.
- Legal op latency, with acceptance edge E0:
  - LOAD during E0–E1, EXEC during E1–E2 (ALU_EN high).
  - The ALU asserts valid after E3; the controller samples it at E4.
  - RSP_VALID rises after E4, i.e. 4 cycles after acceptance.
- Rejected op: RSP_VALID rises after E0 (1-cycle latency).
- Back-to-back throughput: with RSP_READY tied high, one op per 6 cycles.
- ALU_EN is never high on two consecutive cycles; the ALU suppresses valid for back-to-back enables.
- Timeout counter clears on entering WAIT and increments each WAIT cycle. Timeout fires when count==TIMEOUT_CYCLES-1 with no valid.
- A late ALU_RESULT_VALID arriving outside WAIT is ignored.
- Simultaneous VALID on both ports at reset exit: requester 0 wins first.
- A requester dropping VALID before acceptance is permitted; nothing is captured.
- RST asserted mid-operation: all state returns to reset values immediately and any in-flight result is discarded. The ALU is reset by the same event.

## Test plan
- Single legal request:
  - REQ0 A=0x12, B=0x34, FUNC=0 (add) -> RSP_VALID 4 cycles after acceptance, ID=0, DATA=0x0046, ERR=0.
  - ALU_EN high for exactly one cycle.
- Contention:
  - Both VALID continuously: REQ0 (FUNC=2, 0x0F*0x10) and REQ1 (FUNC=8, 0xAA^0x55), RSP_READY=1.
  - Grants alternate 0,1,0,1; responses are ID0 DATA=0x00F0 and ID1 DATA=0x00FF; each accepted payload is captured only on the grant cycle.
- Illegal operations:
  - FUNC=14 -> 1-cycle response, DATA=0, ERR=1, ALU_EN never asserted.
  - FUNC=3 with B=0 -> same response.
- Backpressure:
  - RSP_READY=0 for 5 cycles after RSP_VALID -> ID/DATA/ERR stable and both READY low.
  - Release -> IDLE next cycle.
- Timeout:
  - ALU model never asserts valid -> ERR=1, DATA=0 after TIMEOUT_CYCLES WAIT cycles; the next request is served normally.
- Reset mid-op:
  - Assert RST during WAIT -> all outputs at reset values asynchronously, no response emitted.
  - After release, a REQ1 request for 0x80>>1 (FUNC=12) returns DATA=0x0040.
